dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Latency: grant -> rsp_valid in 2 cycles (load, full/no-op store) or 3 cycles (partial store RMW).
// Backpressure: one request in flight; ready only in IDLE for the winner, loser holds its request.
//
// Ports: clk/reset (sync, active-high); per requester rN_valid/ready/we/addr/wdata/be in,
//        rN_rsp_valid/rsp_rdata out; memory side mem_we/mem_a/mem_wd out, mem_rd in (comb read).
module dmem_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [DW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [3:0]    r0_be,
    output logic          r0_rsp_valid,
    output logic [DW-1:0] r0_rsp_rdata,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [DW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [3:0]    r1_be,
    output logic          r1_rsp_valid,
    output logic [DW-1:0] r1_rsp_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t        state, state_nxt;
    logic          last;        // requester served most recently
    logic          lat_id;
    logic          lat_we;
    logic [DW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    lat_be;
    logic [DW-1:0] merged;

    logic          grant_vld;
    logic          grant_id;
    logic          full_st;
    logic          part_st;
    logic [DW-1:0] merge_w;
    logic [DW-1:0] word_a;

    // On a tie the requester not served last wins; otherwise the lone requester wins.
    assign grant_vld = r0_valid | r1_valid;
    assign grant_id  = (r0_valid & r1_valid) ? ~last : r1_valid;

    assign full_st = lat_we && (lat_be == 4'hF);
    assign part_st = lat_we && (lat_be != 4'h0) && (lat_be != 4'hF);
    assign word_a  = {lat_addr[DW-1:2], 2'b00};

    // Read-modify-write merge: enabled lanes from the store, the rest from memory.
    always_comb begin
        merge_w = '0;
        for (int k = 0; k < 4; k++) begin
            merge_w[8*k +: 8] = lat_be[k] ? lat_wdata[8*k +: 8] : mem_rd[8*k +: 8];
        end
    end

    always_comb begin
        state_nxt    = state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        mem_we       = 1'b0;
        mem_a        = '0;
        mem_wd       = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    r0_ready  = ~grant_id;
                    r1_ready  = grant_id;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_a = word_a;
                if (full_st) begin
                    mem_we = 1'b1;
                    mem_wd = lat_wdata;
                end
                state_nxt = part_st ? WRITE : RESP;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_a     = word_a;
                mem_wd    = merged;
                state_nxt = RESP;
            end
            RESP: begin
                r0_rsp_valid = ~lat_id;
                r1_rsp_valid = lat_id;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset masks every output, including a store that would otherwise commit on this edge.
        if (reset) begin
            r0_ready     = 1'b0;
            r1_ready     = 1'b0;
            r0_rsp_valid = 1'b0;
            r1_rsp_valid = 1'b0;
            mem_we       = 1'b0;
            mem_a        = '0;
            mem_wd       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            lat_id       <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            merged       <= '0;
            r0_rsp_rdata <= '0;
            r1_rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        last      <= grant_id;
                        lat_id    <= grant_id;
                        lat_we    <= grant_id ? r1_we    : r0_we;
                        lat_addr  <= grant_id ? r1_addr  : r0_addr;
                        lat_wdata <= grant_id ? r1_wdata : r0_wdata;
                        lat_be    <= grant_id ? r1_be    : r0_be;
                    end
                end
                ACCESS: begin
                    if (part_st) merged <= merge_w;
                    // Stores return zero data; loads return the addressed word.
                    if (lat_id) r1_rsp_rdata <= lat_we ? '0 : mem_rd;
                    else        r0_rsp_rdata <= lat_we ? '0 : mem_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model (memory array, round-robin
// pointer, busy window) predicts ready, response timing/data and memory traffic per cycle.
// Directed scenarios first, then randomized traffic, then a reset during a partial store.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r0_valid, r0_ready, r0_we, r0_rsp_valid;
    logic [31:0] r0_addr, r0_wdata, r0_rsp_rdata;
    logic [3:0]  r0_be;
    logic        r1_valid, r1_ready, r1_we, r1_rsp_valid;
    logic [31:0] r1_addr, r1_wdata, r1_rsp_rdata;
    logic [3:0]  r1_be;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    dmem_arbiter #(.DW(32)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_be(r0_be), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_be(r1_be), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Word memory behind the arbiter (addresses 0..255 used).
    logic [31:0] ram [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (pre_we)      ram[pre_idx]     <= pre_val;
        else if (mem_we) ram[mem_a[7:2]]  <= mem_wd;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t q0[$];
    req_t q1[$];

    // Reference model state
    logic [31:0] mdl [0:63];
    int          cyc, free_at, resp_at, acc_at, wr_at, resp_id;
    logic [31:0] resp_dat, exp_addr, exp_acc_wd, exp_wr_wd;
    logic        exp_full, last_srv, rnd_mode;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   sel;
        r.we    = $urandom_range(0, 1) == 1;
        r.addr  = {24'h0, 8'($urandom_range(0, 255))};
        r.wdata = $urandom;
        sel     = $urandom_range(0, 3);
        r.be    = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
        return r;
    endfunction

    function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = a; r.wdata = d; r.be = be;
        return r;
    endfunction

    task automatic drive();
        r0_valid = q0.size() > 0;
        r1_valid = q1.size() > 0;
        {r0_we, r0_addr, r0_wdata, r0_be} = r0_valid ? q0[0] : '0;
        {r1_we, r1_addr, r1_wdata, r1_be} = r1_valid ? q1[0] : '0;
    endtask

    // Apply the request's effect at grant time; only one request is ever in flight.
    task automatic model_grant(input int w, input req_t r);
        int          idx;
        logic [31:0] m;
        idx      = int'(r.addr[7:2]);
        last_srv = w[0];
        acc_at   = cyc + 1;
        exp_addr = {r.addr[31:2], 2'b00};
        exp_full = 1'b0;
        resp_id  = w;
        resp_at  = cyc + 2;
        if (!r.we) begin
            resp_dat = mdl[idx];
        end else begin
            resp_dat = 32'h0;
            if (r.be == 4'hF) begin
                exp_full   = 1'b1;
                exp_acc_wd = r.wdata;
                mdl[idx]   = r.wdata;
            end else if (r.be != 4'h0) begin
                m = mdl[idx];
                for (int k = 0; k < 4; k++)
                    if (r.be[k]) m[8*k +: 8] = r.wdata[8*k +: 8];
                mdl[idx]  = m;
                exp_wr_wd = m;
                wr_at     = cyc + 2;
                resp_at   = cyc + 3;
            end
        end
        free_at = resp_at + 1;
    endtask

    logic hs0, hs1;

    task automatic step();
        logic e0, e1, v0, v1;
        int   w;
        @(negedge clk);
        e0 = 1'b0; e1 = 1'b0; w = 0;
        if (cyc >= free_at && (r0_valid || r1_valid)) begin
            w = (r0_valid && r1_valid) ? (last_srv ? 0 : 1) : (r1_valid ? 1 : 0);
            if (w == 0) e0 = 1'b1; else e1 = 1'b1;
        end
        check("r0_ready", {31'h0, r0_ready}, {31'h0, e0});
        check("r1_ready", {31'h0, r1_ready}, {31'h0, e1});
        v0 = (cyc == resp_at) && (resp_id == 0);
        v1 = (cyc == resp_at) && (resp_id == 1);
        check("r0_rsp_valid", {31'h0, r0_rsp_valid}, {31'h0, v0});
        check("r1_rsp_valid", {31'h0, r1_rsp_valid}, {31'h0, v1});
        if (v0) check("r0_rsp_rdata", r0_rsp_rdata, resp_dat);
        if (v1) check("r1_rsp_rdata", r1_rsp_rdata, resp_dat);
        if (cyc == acc_at) begin
            check("access_mem_a", mem_a, exp_addr);
            check("access_mem_we", {31'h0, mem_we}, {31'h0, exp_full});
            if (exp_full) check("access_mem_wd", mem_wd, exp_acc_wd);
        end else if (cyc == wr_at) begin
            check("write_mem_we", {31'h0, mem_we}, 32'h1);
            check("write_mem_a", mem_a, exp_addr);
            check("write_mem_wd", mem_wd, exp_wr_wd);
        end else begin
            check("quiet_mem_we", {31'h0, mem_we}, 32'h0);
            check("quiet_mem_a", mem_a, 32'h0);
            check("quiet_mem_wd", mem_wd, 32'h0);
        end
        if (e0) model_grant(0, q0[0]);
        if (e1) model_grant(1, q1[0]);
        hs0 = r0_valid && r0_ready;
        hs1 = r1_valid && r1_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        if (rnd_mode) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
        end
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) check("drain_timeout", 32'h1, 32'h0);
    endtask

    task automatic model_reset();
        last_srv = 1'b1;
        free_at  = cyc;
        resp_at  = -1;
        acc_at   = -1;
        wr_at    = -1;
        resp_id  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {30'h0, r0_ready, r1_ready}, 32'h0);
        check({tag, "_rsp_valid"}, {30'h0, r0_rsp_valid, r1_rsp_valid}, 32'h0);
        check({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        check({tag, "_mem_a"}, mem_a, 32'h0);
        check({tag, "_mem_wd"}, mem_wd, 32'h0);
    endtask

    initial begin
        logic [31:0] saved;
        int          n;
        cyc = 0; rnd_mode = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
        model_reset();
        reset = 1'b1;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        // Valids held high during reset to show ready stays low.
        {r0_we, r0_addr, r0_wdata, r0_be} = {1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF};
        {r1_we, r1_addr, r1_wdata, r1_be} = {1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF};
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pre_we  = 1'b1;
            pre_idx = 6'(i);
            pre_val = (i == 2) ? 32'h1122_3344 : (i == 3) ? 32'h55AA_55AA : $urandom;
            mdl[i]  = pre_val;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        check_reset_outputs("in_reset");
        @(posedge clk);
        #1;

        // Directed: tie from reset alternates r0,r1; then store/load scenarios.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0));
            q1.push_back(mk(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0));
        end
        q0.push_back(mk(1'b1, 32'h4, 32'hABCD_1234, 4'hF));
        q0.push_back(mk(1'b0, 32'h4, 32'h0, 4'h0));
        q0.push_back(mk(1'b0, 32'h7, 32'h0, 4'h0));
        q1.push_back(mk(1'b1, 32'h8, 32'h0000_BEEF, 4'b0011));
        q1.push_back(mk(1'b0, 32'h8, 32'h0, 4'h0));
        q1.push_back(mk(1'b1, 32'hC, 32'hDEAD_BEEF, 4'h0));
        q1.push_back(mk(1'b0, 32'hC, 32'h0, 4'h0));
        reset = 1'b0;
        cyc = 0;
        model_reset();
        drive();
        drain();
        check("word4_after_store", ram[1], 32'hABCD_1234);
        check("word8_after_merge", ram[2], 32'h1122_BEEF);
        check("wordC_after_noop", ram[3], 32'h55AA_55AA);

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (1500) step();
        rnd_mode = 1'b0;
        drain();
        for (int i = 0; i < 64; i++) check("ram_vs_model", ram[i], mdl[i]);

        // Reset while a partial store to 0x10 is in ACCESS.
        saved = mdl[4];
        q0.push_back(mk(1'b1, 32'h10, ~saved, 4'b0101));
        drive();
        n = 0;
        hs0 = 1'b0;
        while (!hs0 && n < 20) begin
            step();
            n++;
        end
        if (!hs0) check("reset_grant_timeout", 32'h1, 32'h0);
        reset = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_midop");
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        mdl[4] = saved;
        model_reset();
        q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        q1.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        drive();
        drain();
        check("word10_not_committed", ram[4], saved);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
